// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with synchronised row inputs, press/release
// debouncing, multi-key rejection and a held-key indication.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [3:0]  pattern_q, pattern_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  sync_meta_q, sync_row_q;
  logic [1:0]  row_idx;
  logic        pattern_one_hot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta_q <= '0;
      sync_row_q  <= '0;
    end else begin
      sync_meta_q <= row;
      sync_row_q  <= sync_meta_q;
    end
  end

  assign pattern_one_hot = (pattern_q != 4'd0) && ((pattern_q & (pattern_q - 4'd1)) == 4'd0);

  always_comb begin
    case (pattern_q)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    pattern_d   = pattern_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        col_idx_d = '0;
        if (scan_en) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!scan_en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (sync_row_q != 4'd0) begin
            state_d   = S_DEBOUNCE;
            pattern_d = sync_row_q;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DEBOUNCE: begin
        if (!scan_en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (sync_row_q != pattern_q) begin
          state_d   = S_SCAN;
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d = '0;
          // Multi-key patterns are only rejected once stable, then scanning moves on.
          if (pattern_one_hot) begin
            state_d     = S_PRESSED;
            key_valid_d = 1'b1;
            key_code_d  = {col_idx_q, row_idx};
          end else begin
            state_d   = S_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PRESSED: begin
        if (sync_row_q == 4'd0) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (sync_row_q != 4'd0) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = S_SCAN;
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      col_idx_q   <= '0;
      pattern_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      pattern_q   <= pattern_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col       = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = (state_q == S_PRESSED) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical 4x4 key matrix drives the rows from
// the scanned column, and expected timing follows from dwell/debounce arithmetic.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] keys = 16'h0000;
  int          errors = 0;
  int          checks = 0;
  int          valid_count = 0;
  logic        valid_allowed = 1'b0;
  logic [3:0]  exp_code = 4'h0;
  logic [3:0]  last_code = 4'h0;
  logic        prev_valid = 1'b0;
  logic        prev_held = 1'b0;

  always #5 clk = ~clk;

  // Closed switches connect the driven column to their row line.
  always_comb begin
    row = 4'b0000;
    for (int c = 0; c < 4; c++)
      if (col[c]) row = row | keys[c*4 +: 4];
  end

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input logic en);
    keys    = k;
    scan_en = en;
  endtask

  // One clock; every cycle the pulse legality and key_code retention are scored.
  task automatic step();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) begin
      valid_count++;
      checkOutput("valid_legal", {29'd0, valid_allowed, prev_valid, prev_held}, 32'h4);
      checkOutput("valid_code", key_code, exp_code);
      last_code = exp_code;
    end else begin
      checkOutput("code_retain", key_code, last_code);
    end
    prev_valid = key_valid;
    prev_held  = key_held;
  endtask

  task automatic waitCol(input logic [3:0] target);
    int n = 0;
    while (col !== target && n < 8*SD) begin step(); n++; end
    checkOutput("wait_col", col, target);
  endtask

  task automatic waitNotCol(input logic [3:0] target);
    int n = 0;
    while (col === target && n < 8*SD) begin step(); n++; end
    checkOutput("wait_not_col", (col !== target), 1);
  endtask

  function automatic logic [15:0] keyBit(input logic [1:0] c, input logic [1:0] r);
    return 16'h0001 << (int'(c)*4 + int'(r));
  endfunction

  // Key closed while another column is driven: valid appears SD+DB cycles after its column first drives.
  task automatic doPress(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] target;
    int n = 0;
    int v0;
    target = 4'b0001 << c;
    exp_code = {c, r};
    valid_allowed = 1'b1;
    v0 = valid_count;
    waitNotCol(target);
    applyStimulus(keyBit(c, r), 1'b1);
    waitCol(target);
    while (key_valid !== 1'b1 && n < SD+DB+10) begin step(); n++; end
    valid_allowed = 1'b0;
    checkOutput("press_latency", n, SD+DB);
    checkOutput("press_code", key_code, {c, r});
    checkOutput("press_held", key_held, 1);
    checkOutput("press_count", valid_count - v0, 1);
  endtask

  // Row has just dropped to zero: held stays up through sync + detect + DB counting cycles.
  task automatic releaseTail(input logic [1:0] c);
    logic lost = 1'b0;
    for (int k = 1; k <= 2+DB; k++) begin
      step();
      if (key_held !== 1'b1) lost = 1'b1;
    end
    checkOutput("release_held", lost, 0);
    step();
    checkOutput("release_drop", key_held, 0);
    checkOutput("release_next_col", col, 4'b0001 << (c + 2'd1));
  endtask

  initial begin
    logic [1:0] rc, rr;
    int v0;
    logic saw_adv;
    logic lost;

    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_col", col, 0);
    checkOutput("reset_valid", key_valid, 0);
    checkOutput("reset_code", key_code, 0);
    checkOutput("reset_held", key_held, 0);
    rst = 1'b1;

    $display("[TB] idle sweep");
    applyStimulus(16'h0000, 1'b1);
    for (int k = 1; k <= 5*SD; k++) begin
      step();
      checkOutput("sweep_col", col, 4'b0001 << (((k-1)/SD) % 4));
    end
    checkOutput("sweep_no_valid", valid_count, 0);
    applyStimulus(16'h0000, 1'b0);
    step();
    checkOutput("scan_off_idle", col, 0);
    applyStimulus(16'h0000, 1'b1);
    repeat (3) step();

    $display("[TB] clean press");
    doPress(2'd1, 2'd2);
    checkOutput("clean_code", key_code, 4'b0110);
    repeat (28) step();
    applyStimulus(16'h0000, 1'b1);
    releaseTail(2'd1);

    $display("[TB] async reset mid-debounce");
    rc = 2'($urandom_range(0, 3));
    rr = 2'($urandom_range(0, 3));
    waitNotCol(4'b0001 << rc);
    applyStimulus(keyBit(rc, rr), 1'b1);
    waitCol(4'b0001 << rc);
    repeat (6) step();
    #3;
    rst = 1'b0;
    #1;
    checkOutput("abort_col", col, 0);
    checkOutput("abort_held", key_held, 0);
    checkOutput("abort_code", key_code, 0);
    checkOutput("abort_valid", key_valid, 0);
    last_code = 4'h0;
    prev_valid = 1'b0;
    prev_held = 1'b0;
    step();
    step();
    rst = 1'b1;
    exp_code = {rc, rr};
    valid_allowed = 1'b1;
    v0 = valid_count;
    waitCol(4'b0001 << rc);
    begin
      int n = 0;
      while (key_valid !== 1'b1 && n < SD+DB+10) begin step(); n++; end
      checkOutput("rescan_latency", n, SD+DB);
    end
    valid_allowed = 1'b0;
    checkOutput("rescan_count", valid_count - v0, 1);
    repeat (3) step();
    applyStimulus(16'h0000, 1'b1);
    releaseTail(rc);

    $display("[TB] bounce during debounce");
    v0 = valid_count;
    waitNotCol(4'b0100);
    applyStimulus(keyBit(2'd2, 2'd0), 1'b1);
    waitCol(4'b0100);
    repeat (5) step();
    applyStimulus(16'h0000, 1'b1);
    repeat (3) step();
    applyStimulus(keyBit(2'd2, 2'd0), 1'b1);
    repeat (3) step();
    applyStimulus(16'h0000, 1'b1);
    repeat (3) step();
    checkOutput("bounce_quiet", valid_count - v0, 0);
    exp_code = 4'b1000;
    valid_allowed = 1'b1;
    applyStimulus(keyBit(2'd2, 2'd0), 1'b1);
    begin
      int n = 0;
      while (key_valid !== 1'b1 && n < 6*SD+DB+10) begin step(); n++; end
    end
    valid_allowed = 1'b0;
    checkOutput("bounce_valid", key_valid, 1);
    checkOutput("bounce_count", valid_count - v0, 1);
    repeat (4) step();
    applyStimulus(16'h0000, 1'b1);
    releaseTail(2'd2);

    $display("[TB] multi-key");
    v0 = valid_count;
    saw_adv = 1'b0;
    waitNotCol(4'b0001);
    applyStimulus(16'h0003, 1'b1);
    waitCol(4'b0001);
    for (int k = 0; k < 30; k++) begin
      step();
      if (col === 4'b0010) saw_adv = 1'b1;
    end
    checkOutput("multi_advance", saw_adv, 1);
    checkOutput("multi_no_valid", valid_count - v0, 0);
    checkOutput("multi_held", key_held, 0);
    applyStimulus(16'h0000, 1'b1);
    repeat (2*SD) step();

    $display("[TB] release glitch");
    v0 = valid_count;
    doPress(2'd3, 2'd1);
    repeat (4) step();
    lost = 1'b0;
    applyStimulus(16'h0000, 1'b1);
    repeat (5) begin step(); if (key_held !== 1'b1) lost = 1'b1; end
    applyStimulus(keyBit(2'd3, 2'd1), 1'b1);
    repeat (2) begin step(); if (key_held !== 1'b1) lost = 1'b1; end
    applyStimulus(16'h0000, 1'b1);
    checkOutput("glitch_held", lost, 0);
    releaseTail(2'd3);
    checkOutput("glitch_single_valid", valid_count - v0, 1);

    $display("[TB] scan_en dropped while pressed");
    doPress(2'd0, 2'd3);
    applyStimulus(keyBit(2'd0, 2'd3), 1'b0);
    lost = 1'b0;
    repeat (6) begin step(); if (key_held !== 1'b1) lost = 1'b1; end
    checkOutput("scan_off_held", lost, 0);
    applyStimulus(16'h0000, 1'b0);
    releaseTail(2'd0);
    step();
    checkOutput("scan_off_to_idle", col, 0);
    applyStimulus(16'h0000, 1'b1);

    $display("[TB] random presses");
    for (int t = 0; t < 5; t++) begin
      rc = 2'($urandom_range(0, 3));
      rr = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 9)) step();
      doPress(rc, rr);
      repeat ($urandom_range(1, 20)) step();
      applyStimulus(16'h0000, 1'b1);
      releaseTail(rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column is driven during scanning; legal range 2..65535.
REQ-002 Parameter DEBOUNCE, default 20000, consecutive stable cycles required to accept a press or a release; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; assertion acts immediately, deassertion is synchronous to clk.
REQ-005 scan_en  input  1  synchronous scan enable; high = scanning active.
REQ-006 row  input  4  raw keypad row lines, asynchronous to clk, active-high (1 = key closed on the driven column).
REQ-007 col  output  4  column drive, one-hot active-high, or all-zero when idle.
REQ-008 key_valid  output  1  one-cycle pulse marking a debounced new key press.
REQ-009 key_code  output  4  code of the last accepted key, {col_idx[1:0], row_idx[1:0]}.
REQ-010 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer (sync_row); all decisions use sync_row only, giving 2 cycles of input latency.
REQ-012 The FSM SHALL have exactly the states IDLE, SCAN, DEBOUNCE, PRESSED, and RELEASE.
REQ-013 IDLE: col=0000, counters cleared; go to SCAN with col_idx=0 when scan_en=1.
REQ-014 SCAN: col=one-hot(col_idx); dwell counter counts 0..SCAN_DIV-1; at count SCAN_DIV-1, sync_row!=0 -> DEBOUNCE, latching sync_row as captured pattern; otherwise col_idx increments mod 4 (3 wraps to 0) and dwell restarts.
REQ-015 DEBOUNCE: col held; the counter increments each cycle in which sync_row equals the captured pattern.
REQ-016 DEBOUNCE: a sync_row change -> SCAN with col_idx+1 and no output.
REQ-017 DEBOUNCE: when the count reaches DEBOUNCE-1 with a one-hot pattern -> PRESSED, key_valid=1 for that single cycle, and key_code updated in the same cycle.
REQ-018 DEBOUNCE: a pattern with more than one bit set (multi-key) SHALL be rejected -> SCAN with col_idx+1 and no key_valid.
REQ-019 row_idx SHALL be the index of the single set bit in the captured pattern (bit0 -> 0 ... bit3 -> 3).
REQ-020 PRESSED: key_held=1, col held; sync_row==0 -> RELEASE with the counter cleared.
REQ-021 RELEASE: key_held=1; the counter increments while sync_row==0; any nonzero sync_row -> PRESSED with the counter cleared; at count DEBOUNCE-1 -> SCAN with col_idx+1, key_held=0 on entry to SCAN.
REQ-022 key_code SHALL retain its value until the next key_valid.
REQ-023 key_valid SHALL never assert on two consecutive cycles, and never while key_held was already 1.
REQ-024 scan_en=0 in SCAN or DEBOUNCE -> IDLE next cycle with no key_valid.
REQ-025 scan_en=0 in PRESSED or RELEASE -> no effect until return to SCAN, then IDLE.
REQ-026 Counters SHALL be 16 bits and saturate-free within the legal parameter range; a wrap is not permitted.

Reset
REQ-027 While rst=0: state=IDLE, col=0000, key_valid=0, key_code=0000, key_held=0, col_idx=0, counters=0, synchronizer flops=0.
REQ-028 Reset asserted mid-DEBOUNCE, PRESSED, or RELEASE SHALL abort immediately with no key_valid and key_held=0.
REQ-029 After rst returns to 1, the first key_valid SHALL require a full new scan and debounce.

Verification (SCAN_DIV=4, DEBOUNCE=8)
REQ-030 Idle sweep: scan_en=1, row=0000 -> col cycles 0001,0010,0100,1000,0001 with 4 cycles each; key_valid never asserts.
REQ-031 Clean press: row=0100 applied only while col=0010 and held for 40 cycles -> exactly one key_valid with key_code=0110, and key_held=1 until 8 cycles after row returns to 0000 (+2-cycle sync latency).
REQ-032 Bounce: row toggles 0001/0000 every 3 cycles during DEBOUNCE -> no key_valid; once row is stable, a single key_valid follows.
REQ-033 Multi-key: row=0011 held on col=0001 -> no key_valid; col keeps advancing.
REQ-034 Release bounce: during RELEASE, row glitches to 0100 for 2 cycles -> returns to PRESSED, no second key_valid, key_held stays 1.
REQ-035 Async reset: rst=0 mid-DEBOUNCE -> col=0000, key_held=0, key_code=0000 immediately without waiting for a clk edge; no key_valid after release until a full rescan completes.
